// File: rtl/arm_mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM controller (arm_mc_ctrl_v2).
package arm_mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECR, EXECI, ALUWB, BRANCH, HALT
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000, CMD_EOR = 4'b0001, CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100, CMD_TST = 4'b1000, CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100, CMD_MOV = 4'b1101;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       writes_rd;
    logic       sets_flags;
  } dp_dec_t;

  typedef struct packed {
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] reg_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [2:0] alu_ctl;
  } ctrl_t;

  // Compare/test only update flags; unknown commands behave as a silent ADD.
  function automatic dp_dec_t decode_dp(input logic [3:0] cmd, input logic s);
    dp_dec_t d;
    d.alu_op     = ALU_ADD;
    d.writes_rd  = 1'b1;
    d.sets_flags = s;
    case (cmd)
      CMD_ADD: d.alu_op = ALU_ADD;
      CMD_SUB: d.alu_op = ALU_SUB;
      CMD_AND: d.alu_op = ALU_AND;
      CMD_ORR: d.alu_op = ALU_ORR;
      CMD_EOR: d.alu_op = ALU_EOR;
      CMD_MOV: d.alu_op = ALU_MOV;
      CMD_CMP: begin d.alu_op = ALU_SUB; d.writes_rd = 1'b0; d.sets_flags = 1'b1; end
      CMD_TST: begin d.alu_op = ALU_AND; d.writes_rd = 1'b0; d.sets_flags = 1'b1; end
      default: d.writes_rd = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/arm_cond_check.sv
// Combinational ARM condition-code evaluator against a stored NZCV value.
module arm_cond_check
  import arm_mc_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_mc_ctrl_v2.sv
// Multicycle ARM control FSM. Define ARM_MC_CTRL_MEM_WAIT_EN to make memory
// states wait on MemReady with a stall timeout that faults into HALT.
module arm_mc_ctrl_v2
  import arm_mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W   = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:12]         Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           RegSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Fault
);

  state_t     state, state_next;
  ctrl_t      ctrl;
  dp_dec_t    dp;
  logic [3:0] nzcv;
  logic       cond_ex, cond_ok;
  logic [1:0] op;
  logic [3:0] cmd, rd;
  logic       imm, s_bit, load;
  logic       mem_ready, stall, timeout;
  logic       unused_bits;

  assign op    = Instr[27:26];
  assign imm   = Instr[25];
  assign cmd   = Instr[24:21];
  assign s_bit = Instr[20];
  assign load  = Instr[20];
  assign rd    = Instr[15:12];
  assign dp    = decode_dp(cmd, s_bit);

  arm_cond_check u_cond (
    .cond    (Instr[31:28]),
    .nzcv    (nzcv),
    .cond_ex (cond_ex)
  );

`ifdef ARM_MC_CTRL_MEM_WAIT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             fault_q;

  assign mem_ready = MemReady;
  assign stall     = !MemReady && (state == FETCH || state == MEMRD || state == MEMWR);
  assign timeout   = stall && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      wait_cnt <= stall ? wait_cnt + CNT_W'(1) : '0;
      if (timeout) fault_q <= 1'b1;
    end
  end

  assign Fault       = fault_q;
  assign unused_bits = ^Instr[19:16];
`else
  assign mem_ready   = 1'b1;
  assign stall       = 1'b0;
  assign timeout     = 1'b0;
  assign Fault       = 1'b0;
  assign unused_bits = ^{Instr[19:16], MemReady, stall} ^ (MEM_TIMEOUT > 0);
`endif

  // The condition is latched in DECODE so a flag update in EXEC cannot
  // change the fate of the same instruction's writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      nzcv    <= 4'b0000;
      cond_ok <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE) cond_ok <= cond_ex;
      if ((state == EXECR || state == EXECI) && dp.sets_flags && cond_ok) nzcv <= ALUFlags;
    end
  end

  always_comb begin
    state_next = state;
    ctrl       = '0;
    case (state)
      FETCH: begin
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
        ctrl.alu_src_a  = 2'b01;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
        ctrl.alu_ctl    = ALU_ADD;
        if (timeout)        state_next = HALT;
        else if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        ctrl.alu_src_a  = 2'b01;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
        ctrl.reg_src    = {op == OP_MEM && !load, op == OP_BR};
        ctrl.imm_src    = op;
        case (op)
          OP_DP:   state_next = imm ? EXECI : EXECR;
          OP_MEM:  state_next = MEMADR;
          OP_BR:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ctrl.alu_src_b = 2'b01;
        ctrl.imm_src   = OP_MEM;
        state_next     = load ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctrl.adr_src = 1'b1;
        if (timeout)        state_next = HALT;
        else if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_write  = cond_ok;
        state_next      = FETCH;
      end
      MEMWR: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = cond_ok && mem_ready;
        if (timeout)        state_next = HALT;
        else if (mem_ready) state_next = FETCH;
      end
      EXECR: begin
        ctrl.alu_ctl = dp.alu_op;
        state_next   = ALUWB;
      end
      EXECI: begin
        ctrl.alu_src_b = 2'b01;
        ctrl.imm_src   = OP_DP;
        ctrl.alu_ctl   = dp.alu_op;
        state_next     = ALUWB;
      end
      ALUWB: begin
        ctrl.result_src = 2'b00;
        ctrl.reg_write  = cond_ok && dp.writes_rd && (rd != 4'hF);
        ctrl.pc_write   = cond_ok && dp.writes_rd && (rd == 4'hF);
        state_next      = FETCH;
      end
      BRANCH: begin
        ctrl.result_src = 2'b00;
        ctrl.alu_src_b  = 2'b01;
        ctrl.imm_src    = OP_BR;
        ctrl.alu_ctl    = ALU_ADD;
        ctrl.pc_write   = cond_ok;
        state_next      = FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // Outputs drop to zero in the very cycle reset is high, not one cycle later.
  always_comb begin
    {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc} = '0;
    ALUControl = '0;
    if (!reset) begin
      {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc} =
        {ctrl.pc_write, ctrl.mem_write, ctrl.reg_write, ctrl.ir_write, ctrl.adr_src};
      {RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc} =
        {ctrl.reg_src, ctrl.alu_src_a, ctrl.alu_src_b, ctrl.result_src, ctrl.imm_src};
      ALUControl = ALUCTRL_W'(ctrl.alu_ctl);
    end
  end

endmodule

// File: tb/tb_arm_mc_ctrl_v2.sv
// Scoreboard bench for arm_mc_ctrl_v2; extra memory-wait scenarios are compiled
// in when ARM_MC_CTRL_MEM_WAIT_EN is defined.
module tb_arm_mc_ctrl_v2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = '0;
  logic [3:0]  ALUFlags = '0;
  logic        MemReady = 1'b1;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, Fault;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;

  typedef struct packed {
    logic       fault, pcw, memw, regw, irw, adrsrc;
    logic [1:0] regsrc, srca, srcb, ressrc, immsrc;
    logic [2:0] aluctl;
  } outs_t;

  typedef struct {
    outs_t exp;
    outs_t care;
    string tag;
  } item_t;

  typedef enum {P_RESET, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB,
                P_MEMWR, P_EXEC, P_ALUWB, P_BRANCH, P_HALT} phase_t;

  item_t      expQ[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] modelFlags = '0;

  arm_mc_ctrl_v2 #(.ALUCTRL_W(3), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Fault(Fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit condPass(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;           4'h1: return !z;
      4'h2: return c;           4'h3: return !c;
      4'h4: return n;           4'h5: return !n;
      4'h6: return v;           4'h7: return !v;
      4'h8: return c && !z;     4'h9: return !c || z;
      4'hA: return n == v;      4'hB: return n != v;
      4'hC: return !z && n == v; 4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] aluOf(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 3'd0;  4'b0010: return 3'd1;  4'b0000: return 3'd2;
      4'b1100: return 3'd3;  4'b0001: return 3'd4;  4'b1101: return 3'd5;
      4'b1010: return 3'd1;  4'b1000: return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit writesRd(input logic [3:0] cmd);
    return cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1101};
  endfunction

  // Expected outputs for one cycle; muxes not named for a phase are left unchecked.
  function automatic item_t expectFor(input phase_t p, input logic [19:0] ins, input bit ok, input bit ready);
    item_t it;
    logic [1:0] op;
    op = ins[15:14];
    it.exp = '0;
    it.care = '0;
    it.tag = p.name();
    {it.care.fault, it.care.pcw, it.care.memw, it.care.regw, it.care.irw} = 5'b11111;
    case (p)
      P_RESET: it.care = '1;
      P_FETCH: begin
        it.exp.irw = ready; it.exp.pcw = ready;
        it.exp.srca = 2'b01; it.exp.srcb = 2'b10; it.exp.ressrc = 2'b10;
        it.care.adrsrc = 1'b1; it.care.srca = '1; it.care.srcb = '1;
        it.care.ressrc = '1; it.care.aluctl = '1;
      end
      P_DECODE: begin
        it.exp.srca = 2'b01; it.exp.srcb = 2'b10; it.exp.ressrc = 2'b10;
        it.exp.regsrc = {op == 2'b01 && !ins[8], op == 2'b10};
        it.exp.immsrc = op;
        it.care.srca = '1; it.care.srcb = '1; it.care.ressrc = '1;
        it.care.regsrc = '1; it.care.immsrc = '1;
      end
      P_MEMRD: begin it.exp.adrsrc = 1'b1; it.care.adrsrc = 1'b1; end
      P_MEMWB: begin
        it.exp.ressrc = 2'b01; it.care.ressrc = '1;
        it.exp.regw = ok;
      end
      P_MEMWR: begin
        it.exp.adrsrc = 1'b1; it.care.adrsrc = 1'b1;
        it.exp.memw = ok && ready;
      end
      P_EXEC: begin it.exp.aluctl = aluOf(ins[12:9]); it.care.aluctl = '1; end
      P_ALUWB: begin
        it.care.ressrc = '1;
        it.exp.regw = ok && writesRd(ins[12:9]) && ins[3:0] != 4'hF;
        it.exp.pcw  = ok && writesRd(ins[12:9]) && ins[3:0] == 4'hF;
      end
      P_BRANCH: begin
        it.exp.srcb = 2'b01;
        it.care.ressrc = '1; it.care.srcb = '1; it.care.aluctl = '1;
        it.exp.pcw = ok;
      end
      P_HALT: it.exp.fault = 1'b1;
      default: ;
    endcase
    return it;
  endfunction

  task automatic issue(input phase_t p, input logic [19:0] ins, input bit ok, input bit ready);
    expQ.push_back(expectFor(p, ins, ok, ready));
    @(posedge clk); #1;
  endtask

  // One whole instruction from FETCH back to FETCH; memStall only matters with memory waits.
  task automatic applyStimulus(input logic [19:0] ins, input logic [3:0] flags, input int memStall);
    bit ok;
    ok = condPass(ins[19:16], modelFlags);
    Instr = ins;
    ALUFlags = flags;
    MemReady = 1'b1;
    issue(P_FETCH, ins, ok, 1'b1);
    issue(P_DECODE, ins, ok, 1'b1);
    case (ins[15:14])
      2'b00: begin
        issue(P_EXEC, ins, ok, 1'b1);
        issue(P_ALUWB, ins, ok, 1'b1);
        if (ok && (ins[8] || ins[12:9] == 4'b1010 || ins[12:9] == 4'b1000)) modelFlags = flags;
      end
      2'b01: begin
        issue(P_MEMADR, ins, ok, 1'b1);
        for (int i = 0; i < memStall; i++) begin
          MemReady = 1'b0;
          issue(ins[8] ? P_MEMRD : P_MEMWR, ins, ok, 1'b0);
        end
        MemReady = 1'b1;
        issue(ins[8] ? P_MEMRD : P_MEMWR, ins, ok, 1'b1);
        if (ins[8]) issue(P_MEMWB, ins, ok, 1'b1);
      end
      2'b10: issue(P_BRANCH, ins, ok, 1'b1);
      default: ;
    endcase
  endtask

  initial begin : monitor
    outs_t act;
    item_t it;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        it = expQ.pop_front();
        act = {Fault, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
        checkOutput(it.tag, 32'(act & it.care), 32'(it.exp & it.care));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    logic [19:0] ins;
    @(posedge clk); #1;
    issue(P_RESET, Instr, 1'b1, 1'b1);
    issue(P_RESET, Instr, 1'b1, 1'b1);
    reset = 1'b0;
    checkOutput("nzcv_after_reset", 32'(dut.nzcv), 32'(modelFlags));

    applyStimulus(20'hE04F0, 4'b0000, 0);
    applyStimulus(20'hE1500, 4'b0100, 0);
    checkOutput("nzcv_after_cmp_eq", 32'(dut.nzcv), 32'(4'b0100));
    applyStimulus(20'h0A000, 4'b0000, 0);
    applyStimulus(20'hE1500, 4'b0000, 0);
    checkOutput("nzcv_after_cmp_ne", 32'(dut.nzcv), 32'(4'b0000));
    applyStimulus(20'h0A000, 4'b0000, 0);
    applyStimulus(20'h05802, 4'b0000, 0);
    applyStimulus(20'hE28F0, 4'b1111, 0);

    for (int n = 0; n < 300; n++) begin
      ins = {($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hE, 16'($urandom)};
      if ($urandom_range(0, 5) == 0) ins[3:0] = 4'hF;
      applyStimulus(ins, 4'($urandom), 0);
      checkOutput("nzcv_random", 32'(dut.nzcv), 32'(modelFlags));
    end

    applyStimulus(20'hE1500, 4'b1010, 0);
    Instr = 20'hE5902;
    issue(P_FETCH, Instr, 1'b1, 1'b1);
    issue(P_DECODE, Instr, 1'b1, 1'b1);
    issue(P_MEMADR, Instr, 1'b1, 1'b1);
    reset = 1'b1;
    issue(P_RESET, Instr, 1'b1, 1'b1);
    modelFlags = '0;
    checkOutput("nzcv_mid_load_reset", 32'(dut.nzcv), 32'(modelFlags));
    issue(P_RESET, Instr, 1'b1, 1'b1);
    reset = 1'b0;
    applyStimulus(20'hE04F0, 4'b0000, 0);

`ifdef ARM_MC_CTRL_MEM_WAIT_EN
    applyStimulus(20'hE5902, 4'b0000, 3);
    applyStimulus(20'hE5802, 4'b0000, 2);
    Instr = 20'hE04F0;
    MemReady = 1'b0;
    for (int i = 0; i < 15; i++) issue(P_FETCH, Instr, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      MemReady = 1'($urandom);
      issue(P_HALT, Instr, 1'b1, 1'b1);
    end
    reset = 1'b1;
    MemReady = 1'b1;
    issue(P_RESET, Instr, 1'b1, 1'b1);
    reset = 1'b0;
    modelFlags = '0;
    applyStimulus(20'hE04F0, 4'b0000, 0);
`endif

    @(posedge clk); #1;
    checkOutput("queue_drain", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arm_mc_ctrl_v2.md
ARM_MC_CTRL_V2 -- requirements
Module: arm_mc_ctrl_v2

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 3, ALUControl width (min 3).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, max wait cycles per memory state before fault.
REQ-003 SHALL have ports: clk in 1 clock; reset in 1 sync active-high; Instr in 20 [31:12]; ALUFlags in 4 NZCV from ALU; MemReady in 1 memory done.
REQ-004 SHALL have outputs: PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc (1 each); RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc (2 each); ALUControl (ALUCTRL_W); Fault (1, sticky timeout).
REQ-005 SHALL use one clock; reset synchronous, active-high, sampled on clk rising edge.

Function
REQ-006 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, HALT.
REQ-007 Transitions: FETCH->DECODE; DECODE->MEMADR (op=01), EXECR (op=00, I=0), EXECI (op=00, I=1), BRANCH (op=10); MEMADR->MEMRD (L=1) else MEMWR; MEMRD->MEMWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH; EXECR/EXECI->ALUWB; op=11->FETCH.
REQ-008 ALU encodings: ADD 000, SUB 001, AND 010, ORR 011, EOR 100, MOV 101 (pass B); upper bits zero when ALUCTRL_W>3.
REQ-009 DP decode: cmd 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV, 1010 CMP (SUB), 1000 TST (AND); other cmds ADD with RegWrite suppressed.
REQ-010 CMP/TST SHALL never assert RegWrite; S bit forced 1.
REQ-011 Internal NZCV register SHALL capture ALUFlags at end of EXECR/EXECI when S=1 and condition passes.
REQ-012 Condition SHALL evaluate Instr[31:28] against stored NZCV for all 14 ARM codes; 1110 always; 1111 never.
REQ-013 Failed condition SHALL suppress PCWrite in BRANCH, RegWrite in ALUWB/MEMWB, MemWrite in MEMWR, and flag update; state sequence unchanged.
REQ-014 FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
REQ-015 DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10; RegSrc[0]=1 for branch, RegSrc[1]=1 for store; ImmSrc=op.
REQ-016 MEMRD/MEMWR: AdrSrc=1; MEMWB: ResultSrc=01, RegWrite; ALUWB/BRANCH: ResultSrc=00; BRANCH ALUSrcB=01, ALUControl=ADD.
REQ-017 Data-processing writeback to R15 (Instr[15:12]=1111) SHALL assert PCWrite in ALUWB instead of RegWrite.
REQ-018 Write enables SHALL be single-cycle pulses; muxes don't-care outside listed states, driven 0.

Reset
REQ-019 reset high SHALL set state FETCH, NZCV 0000, wait counter 0, Fault 0, all outputs 0 same cycle.
REQ-020 reset mid-operation SHALL abort the instruction; FETCH entered first cycle after release.

Configuration
REQ-021 Macro ARM_MC_CTRL_MEM_WAIT_EN defined: FETCH, MEMRD, MEMWR hold until MemReady=1; IRWrite/PCWrite/MemWrite asserted only in the MemReady=1 cycle; counter counts stall cycles.
REQ-022 Counter reaching MEM_TIMEOUT SHALL set Fault, enter HALT; HALT holds all enables 0 until reset.
REQ-023 Macro undefined: MemReady ignored, memory states single-cycle, Fault tied 0, HALT unreachable.

Structure
REQ-024 Package arm_mc_ctrl_pkg SHALL hold state enum, ALU op localparams, cond-code localparams, op-field constants.
REQ-025 Sub-module arm_cond_check (combinational: cond, NZCV -> CondEx) SHALL be instantiated once.

Verification
REQ-026 Instr=20'hE04F0 (SUB R0,R15,R15), flags 0: FETCH,DECODE,EXECR,ALUWB in 4 cycles; ALUControl=001; RegWrite=1 only in ALUWB.
REQ-027 Instr=20'hE5902 (LDR), MEM_WAIT_EN, MemReady low 3 cycles in MEMRD: 8 cycles total; RegWrite in MEMWB, ResultSrc=01.
REQ-028 CMP (20'hE1500) with ALUFlags=0100, then BEQ 20'h0A000: NZCV=0100, PCWrite=1 in BRANCH; repeat with ALUFlags=0000: PCWrite=0.
REQ-029 STR 20'hE5802 with cond 0000 and Z=0: MemWrite never asserted; returns to FETCH after MEMWR.
REQ-030 MEM_WAIT_EN, MemReady held 0 in FETCH: Fault=1 after 15 stall cycles, HALT, enables 0; reset -> FETCH, Fault=0.
REQ-031 reset asserted during MEMRD: next cycle all outputs 0, NZCV 0000; after release, FETCH outputs per REQ-014.
